// File: rtl/pipelined_alu.sv
// Two-stage pipelined ALU with a valid/ready handshake on both sides.
// Stage 1 captures the operand beat; stage 2 computes and holds the result.
// An internal accumulator serves the ACC/ACLR operations and is updated
// exactly once per beat, when that beat moves from stage 1 into stage 2.
module pipelined_alu #(
  parameter int unsigned            WIDTH    = 3,
  parameter logic [WIDTH-1:0]       ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_PASS = 3'd5,
    OP_ACC  = 3'd6,
    OP_ACLR = 3'd7
  } alu_op_e;

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [2:0]       op_q, op_d;

  // Stage 2 registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;

  // Accumulator
  logic [WIDTH-1:0] acc_q, acc_d;

  // Handshake enables and datapath intermediates
  logic             s2_en_s;
  logic             s1_en_s;
  logic             s1_move_s;
  logic [WIDTH:0]   sum_s;

  // Stage enables: a stage may load when empty or when its content is leaving.
  always_comb begin
    s2_en_s   = !out_valid_q || out_ready;
    s1_en_s   = !s1_valid_q || s2_en_s;
    s1_move_s = s1_valid_q && s2_en_s;
  end

  assign in_ready  = s1_en_s;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;

  // Operation datapath, evaluated on the stage-1 contents in WIDTH+1 bits.
  always_comb begin
    sum_s = '0;
    case (alu_op_e'(op_q))
      OP_ADD:  sum_s = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
      OP_SUB:  sum_s = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, cin_q};
      OP_AND:  sum_s = {1'b0, a_q & b_q};
      OP_OR:   sum_s = {1'b0, a_q | b_q};
      OP_XOR:  sum_s = {1'b0, a_q ^ b_q};
      OP_PASS: sum_s = {1'b0, a_q};
      OP_ACC:  sum_s = {1'b0, acc_q} + {1'b0, a_q} + {{WIDTH{1'b0}}, cin_q};
      OP_ACLR: sum_s = {1'b0, acc_q};
      default: sum_s = '0;
    endcase
  end

  // Stage 1 next state: capture a beat only when it is actually accepted.
  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    op_d       = op_q;
    if (s1_en_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d   = a;
        b_d   = b;
        cin_d = cin;
        op_d  = op;
      end else begin
        a_d   = a_q;
        b_d   = b_q;
        cin_d = cin_q;
        op_d  = op_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next state: load the computed result or hold it while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    if (s2_en_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = sum_s[WIDTH-1:0];
        cout_d   = sum_s[WIDTH];
        zero_d   = (sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
      end else begin
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Accumulator next state: changes only as an ACC/ACLR beat leaves stage 1,
  // so a stalled beat cannot update it twice and back-to-back beats chain.
  always_comb begin
    acc_d = acc_q;
    if (s1_move_s) begin
      case (alu_op_e'(op_q))
        OP_ACC:  acc_d = sum_s[WIDTH-1:0];
        OP_ACLR: acc_d = ACC_INIT;
        default: acc_d = acc_q;
      endcase
    end else begin
      acc_d = acc_q;
    end
  end

  // Pipeline and accumulator registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      op_q        <= 3'd0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      acc_q       <= ACC_INIT;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      acc_q       <= acc_d;
    end
  end

endmodule
